// File: rtl/spine_output_arbiter.sv
// Round-robin arbiter that shares one spine router output port among all requesting inputs.
// A grant is held until end of packet, burst limit, or owner withdrawal, then the port returns to IDLE for one cycle.
module spine_output_arbiter #(
  parameter int NUM_PORTS = 11,
  parameter int IDX_W     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] last,
  input  logic                 out_fifo_full,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 xfer,
  output logic [3:0]           burst_cnt
);

  localparam logic [0:0]       IDLE       = 1'b0;
  localparam logic [0:0]       GRANTED    = 1'b1;
  localparam logic [3:0]       BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PORTS - 1);
  localparam logic [IDX_W:0]   PORTS_EXT  = (IDX_W + 1)'(NUM_PORTS);

  logic [0:0]             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [IDX_W-1:0]       offset;
  logic [IDX_W:0]         sel_sum;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       next_ptr;
  logic                   release_now;

  // Rotate requests so rr_ptr lands on bit 0; the lowest set bit is then the next owner in round-robin order.
  assign req_dbl = {req, req};
  assign req_rot = NUM_PORTS'(req_dbl >> rr_ptr);

  always_comb begin
    offset = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = IDX_W'(i);
      end
    end
  end

  assign sel_sum = {1'b0, rr_ptr} + {1'b0, offset};
  assign sel     = (sel_sum >= PORTS_EXT) ? IDX_W'(sel_sum - PORTS_EXT) : sel_sum[IDX_W-1:0];

  assign xfer     = grant_valid & req[grant_idx] & ~out_fifo_full;
  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Withdrawal releases even while the FIFO is full; the other two causes need a real transfer.
  assign release_now = (xfer & last[grant_idx])
                     | (xfer & (burst_cnt == BURST_LAST))
                     | ~req[grant_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      burst_cnt   <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel;
            grant_idx   <= sel;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
            state       <= GRANTED;
          end
        end
        GRANTED: begin
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            burst_cnt   <= '0;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spine_output_arbiter.sv
// Scoreboard bench for spine_output_arbiter.
// Each stimulus cycle may push the grant it expects; a negedge monitor pops and compares.
module tb_spine_output_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] req;
  logic [10:0] last;
  logic        out_fifo_full;
  logic [10:0] grant;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic        xfer;
  logic [3:0]  burst_cnt;

  typedef struct {
    int cyc;
    int idx;
    int bc;
    bit xf;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  spine_output_arbiter #(.NUM_PORTS(11), .IDX_W(4), .MAX_BURST(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .last(last),
    .out_fifo_full(out_fifo_full),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .xfer(xfer),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs and optionally record the grant expected in that same cycle.
  task automatic apply_stimulus(input bit rst, input logic [10:0] r, input logic [10:0] l, input bit f,
                                input bit ev, input int ei, input int eb, input bit ex);
    reset = rst;
    req = r;
    last = l;
    out_fifo_full = f;
    if (ev) sb.push_back('{cyc, ei, eb, ex});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 11'h0, 11'h0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Monitor: invariant checks every cycle plus in-order scoreboard matching of grants.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (grant_valid) begin
        if (grant !== (11'h1 << grant_idx)) begin
          failures++;
          $display("[TB] FAIL onehot cyc=%0d grant=%h grant_idx=%0d", cyc, grant, grant_idx);
        end
      end else if (grant !== 11'h0 || grant_idx !== 4'd0 || xfer !== 1'b0 || burst_cnt !== 4'd0) begin
        failures++;
        $display("[TB] FAIL idle_outputs cyc=%0d grant=%h idx=%0d xfer=%b bc=%0d required all zero",
                 cyc, grant, grant_idx, xfer, burst_cnt);
      end

      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missed_grant expected cyc=%0d idx=%0d not seen", sb[0].cyc, sb[0].idx);
        void'(sb.pop_front());
      end

      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (grant_valid !== 1'b1 || int'(grant_idx) != e.idx || int'(burst_cnt) != e.bc || xfer !== e.xf) begin
          failures++;
          $display("[TB] FAIL grant_check cyc=%0d got valid=%b idx=%0d bc=%0d xfer=%b required valid=1 idx=%0d bc=%0d xfer=%b",
                   cyc, grant_valid, grant_idx, burst_cnt, xfer, e.idx, e.bc, e.xf);
        end
      end else if (grant_valid === 1'b1) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_grant cyc=%0d idx=%0d required no grant", cyc, grant_idx);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset, then 10 idle cycles.
    apply_stimulus(1'b1, 11'h0, 11'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    mon_en = 1'b1;
    apply_stimulus(1'b1, 11'h0, 11'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) idle_cycle();

    // Single requester on port 3, two-flit packet; then rr_ptr=4 makes port 5 beat port 3.
    apply_stimulus(1'b0, 11'h008, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h008, 11'h000, 1'b0, 1'b1, 3, 0, 1'b1);
    apply_stimulus(1'b0, 11'h008, 11'h008, 1'b0, 1'b1, 3, 1, 1'b1);
    apply_stimulus(1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h028, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h028, 11'h020, 1'b0, 1'b1, 5, 0, 1'b1);
    idle_cycle();

    // Reset asserted mid-grant on port 9.
    apply_stimulus(1'b0, 11'h200, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b1, 11'h200, 11'h000, 1'b0, 1'b1, 9, 0, 1'b1);
    idle_cycle();
    idle_cycle();

    // Round-robin over all ports with single-flit packets: 0..10 then wrap to 0.
    for (int j = 0; j < 24; j++) begin
      if (j % 2 == 1) apply_stimulus(1'b0, 11'h7FF, 11'h7FF, 1'b0, 1'b1, ((j - 1) / 2) % 11, 0, 1'b1);
      else            apply_stimulus(1'b0, 11'h7FF, 11'h7FF, 1'b0, 1'b0, 0, 0, 1'b0);
    end
    idle_cycle();

    // Burst limit on port 5 with port 6 waiting (rr_ptr=1).
    apply_stimulus(1'b0, 11'h060, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 11'h060, 11'h000, 1'b0, 1'b1, 5, k, 1'b1);
    apply_stimulus(1'b0, 11'h060, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h060, 11'h040, 1'b0, 1'b1, 6, 0, 1'b1);
    idle_cycle();

    // Backpressure on port 2 (rr_ptr=7), port 9 requests meanwhile; last during full is ignored.
    apply_stimulus(1'b0, 11'h004, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h004, 11'h000, 1'b0, 1'b1, 2, 0, 1'b1);
    apply_stimulus(1'b0, 11'h004, 11'h000, 1'b1, 1'b1, 2, 1, 1'b0);
    apply_stimulus(1'b0, 11'h204, 11'h000, 1'b1, 1'b1, 2, 1, 1'b0);
    apply_stimulus(1'b0, 11'h204, 11'h004, 1'b1, 1'b1, 2, 1, 1'b0);
    apply_stimulus(1'b0, 11'h204, 11'h000, 1'b1, 1'b1, 2, 1, 1'b0);
    apply_stimulus(1'b0, 11'h204, 11'h000, 1'b1, 1'b1, 2, 1, 1'b0);
    apply_stimulus(1'b0, 11'h204, 11'h000, 1'b0, 1'b1, 2, 1, 1'b1);
    apply_stimulus(1'b0, 11'h204, 11'h000, 1'b0, 1'b1, 2, 2, 1'b1);
    apply_stimulus(1'b0, 11'h204, 11'h000, 1'b0, 1'b1, 2, 3, 1'b1);
    apply_stimulus(1'b0, 11'h200, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h200, 11'h200, 1'b0, 1'b1, 9, 0, 1'b1);
    idle_cycle();

    // Owner withdraw: port 7 (rr_ptr=10) drops while port 1 waits; search wraps 8..10,0,1.
    apply_stimulus(1'b0, 11'h080, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h082, 11'h000, 1'b0, 1'b1, 7, 0, 1'b1);
    apply_stimulus(1'b0, 11'h002, 11'h000, 1'b0, 1'b1, 7, 1, 1'b0);
    apply_stimulus(1'b0, 11'h002, 11'h000, 1'b0, 1'b0, 0, 0, 1'b0);
    apply_stimulus(1'b0, 11'h002, 11'h002, 1'b0, 1'b1, 1, 0, 1'b1);
    for (int i = 0; i < 3; i++) idle_cycle();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
